hazard_stall_ctrl: RTL and testbench

Pipeline control unit that drives the write-enable and flush inputs of the PC and the four pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB). It reads hazard information back out of those buffers and the data memory, then inserts load-use bubbles, squashes wrong-path instructions on a taken branch, and freezes the pipe while data memory is busy. A watchdog halts the pipe if memory stays busy too long.

---
 rtl/hazard_stall_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch squash,
// memory-busy freeze with watchdog halt. Optional perf counters via HAZARD_PERF_EN.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        IFID_UsesRt,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_Rt,
  input  logic        EXMEM_BranchTaken,
  input  logic        MemBusy,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IDEX_Write,
  output logic        EXMEM_Write,
  output logic        MEMWB_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Flush,
  output logic        MEMWB_Flush,
  output logic        MemTimeout,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_MAX_C = 8'(MEM_WAIT_MAX);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] wait_cnt_r;
  logic [7:0] wait_cnt_nxt_s;
  logic [7:0] busy_cnt_s;
  logic       lu_s;

  function automatic logic load_use_hazard(
    input logic       mem_read,
    input logic [4:0] ld_rt,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return mem_read & (ld_rt != 5'd0) &
           ((ld_rt == rs) | (uses_rt & (ld_rt == rt)));
  endfunction

  assign lu_s = load_use_hazard(IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt);

  // Number of consecutive busy cycles including the current one.
  assign busy_cnt_s = (state_r == ST_WAIT) ? (wait_cnt_r + 8'd1) : 8'd1;

  // State, wait counter register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Next-state and pipeline control decode
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    PCWrite        = 1'b0;
    IFID_Write     = 1'b0;
    IDEX_Write     = 1'b0;
    EXMEM_Write    = 1'b0;
    MEMWB_Write    = 1'b0;
    IFID_Flush     = 1'b0;
    IDEX_Flush     = 1'b0;
    EXMEM_Flush    = 1'b0;
    MEMWB_Flush    = 1'b0;
    MemTimeout     = 1'b0;
    if (!RST_n) begin
      state_nxt_s    = ST_RUN;
      wait_cnt_nxt_s = 8'd0;
    end else begin
      case (state_r)
        ST_RUN, ST_WAIT: begin
          if (MemBusy) begin
            // Freeze: only MEM/WB advances, and it takes a bubble.
            MEMWB_Write    = 1'b1;
            MEMWB_Flush    = 1'b1;
            wait_cnt_nxt_s = busy_cnt_s;
            if (busy_cnt_s == WAIT_MAX_C) begin
              state_nxt_s = ST_HALT;
            end else begin
              state_nxt_s = ST_WAIT;
            end
          end else begin
            PCWrite        = 1'b1;
            IFID_Write     = 1'b1;
            IDEX_Write     = 1'b1;
            EXMEM_Write    = 1'b1;
            MEMWB_Write    = 1'b1;
            state_nxt_s    = ST_RUN;
            wait_cnt_nxt_s = 8'd0;
            // Branch beats load-use: the stalled instruction is on the wrong path.
            if (EXMEM_BranchTaken) begin
              IFID_Flush  = 1'b1;
              IDEX_Flush  = 1'b1;
              EXMEM_Flush = 1'b1;
            end else if (lu_s) begin
              PCWrite    = 1'b0;
              IFID_Write = 1'b0;
              IDEX_Flush = 1'b1;
            end else begin
              IDEX_Flush = 1'b0;
            end
          end
        end
        ST_HALT: begin
          MemTimeout     = 1'b1;
          state_nxt_s    = ST_HALT;
          wait_cnt_nxt_s = wait_cnt_r;
        end
        default: begin
          state_nxt_s    = ST_RUN;
          wait_cnt_nxt_s = 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;
  logic        stall_evt_s;
  logic        flush_evt_s;

  assign stall_evt_s = ~PCWrite & (state_r != ST_HALT);
  assign flush_evt_s = IFID_Flush;

  // Saturating stall / flush performance counters
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (stall_evt_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (flush_evt_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end
    end
  end

  assign StallCycles = stall_cnt_r;
  assign FlushCount  = flush_cnt_r;
`else
  assign StallCycles = 32'd0;
  assign FlushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MEM_WAIT_MAX = 16).
module tb_hazard_stall_ctrl;

`ifdef HAZARD_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  localparam logic [8:0] CTL_ZERO   = 9'b00000_0000;
  localparam logic [8:0] CTL_RUN    = 9'b11111_0000;
  localparam logic [8:0] CTL_FREEZE = 9'b00001_0001;
  localparam logic [8:0] CTL_STALL  = 9'b00111_0100;
  localparam logic [8:0] CTL_FLUSH  = 9'b11111_1110;

  logic        CLK;
  logic        RST_n;
  logic [4:0]  IFID_Rs, IFID_Rt, IDEX_Rt;
  logic        IFID_UsesRt, IDEX_MemRead, EXMEM_BranchTaken, MemBusy;
  logic        PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write;
  logic        IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush;
  logic        MemTimeout;
  logic [31:0] StallCycles, FlushCount;
  logic [8:0]  ctl;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  hazard_stall_ctrl #(.MEM_WAIT_MAX(16)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .EXMEM_BranchTaken(EXMEM_BranchTaken), .MemBusy(MemBusy),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
    .EXMEM_Write(EXMEM_Write), .MEMWB_Write(MEMWB_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .EXMEM_Flush(EXMEM_Flush), .MEMWB_Flush(MEMWB_Flush),
    .MemTimeout(MemTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  assign ctl = {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
                IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Apply one cycle of inputs at the falling edge, settle before checking.
  task automatic set_in(input logic mr, input logic [4:0] ld_rt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic br,
                        input logic busy);
    @(negedge CLK);
    IDEX_MemRead = mr; IDEX_Rt = ld_rt; IFID_Rs = rs; IFID_Rt = rt;
    IFID_UsesRt = urt; EXMEM_BranchTaken = br; MemBusy = busy;
    #2;
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
    IFID_UsesRt = 1'b0; EXMEM_BranchTaken = 1'b0; MemBusy = 1'b0;
    #3;
    n_cmp++; if (ctl !== CTL_ZERO) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_ZERO); end
    n_cmp++; if (MemTimeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", MemTimeout); end
    @(posedge CLK); @(posedge CLK); #1;
    n_cmp++; if (StallCycles !== 32'd0 || FlushCount !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", StallCycles, FlushCount); end
    @(negedge CLK); RST_n = 1'b1; #2;
    n_cmp++; if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL reset_release_run: got %b want %b", ctl, CTL_RUN); end
  endtask

  task automatic test_load_use();
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ctl !== CTL_STALL) begin n_fail++; $display("FAIL lu_rs: got %b want %b", ctl, CTL_STALL); end
    exp_stall += PERF;
    set_in(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL lu_resume: got %b want %b", ctl, CTL_RUN); end
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL lu_r0: got %b want %b", ctl, CTL_RUN); end
    set_in(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL lu_rt_unused: got %b want %b", ctl, CTL_RUN); end
    set_in(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (ctl !== CTL_STALL) begin n_fail++; $display("FAIL lu_rt_used: got %b want %b", ctl, CTL_STALL); end
    exp_stall += PERF;
    set_in(1'b1, 5'h15, 5'h05, 5'h05, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL lu_fullwidth: got %b want %b", ctl, CTL_RUN); end
    set_in(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL lu_noload: got %b want %b", ctl, CTL_RUN); end
    n_cmp++; if (StallCycles !== 32'(exp_stall)) begin
      n_fail++; $display("FAIL lu_stallcount: got %0d want %0d", StallCycles, exp_stall); end
  endtask

  task automatic test_branch_lu();
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (ctl !== CTL_FLUSH) begin n_fail++; $display("FAIL br_lu: got %b want %b", ctl, CTL_FLUSH); end
    exp_flush += PERF;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL br_after: got %b want %b", ctl, CTL_RUN); end
    n_cmp++; if (FlushCount !== 32'(exp_flush)) begin
      n_fail++; $display("FAIL br_flushcount: got %0d want %0d", FlushCount, exp_flush); end
  endtask

  task automatic test_mem_busy();
    // Busy has priority over a simultaneous branch.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (ctl !== CTL_FREEZE) begin n_fail++; $display("FAIL busy_br_prio: got %b want %b", ctl, CTL_FREEZE); end
    exp_stall += PERF;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (ctl !== CTL_FREEZE) begin n_fail++; $display("FAIL busy_freeze%0d: got %b want %b", i, ctl, CTL_FREEZE); end
      exp_stall += PERF;
    end
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ctl !== CTL_RUN || MemTimeout !== 1'b0) begin
      n_fail++; $display("FAIL busy_exit: got %b/%b want %b/0", ctl, MemTimeout, CTL_RUN); end
    n_cmp++; if (StallCycles !== 32'(exp_stall)) begin
      n_fail++; $display("FAIL busy_stallcount: got %0d want %0d", StallCycles, exp_stall); end
    // Leaving WAIT with a taken branch flushes in the same cycle.
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    exp_stall += PERF;
    set_in(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (ctl !== CTL_FLUSH) begin n_fail++; $display("FAIL wait_exit_br: got %b want %b", ctl, CTL_FLUSH); end
    exp_flush += PERF;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (FlushCount !== 32'(exp_flush) || StallCycles !== 32'(exp_stall)) begin
      n_fail++; $display("FAIL wait_exit_counts: got %0d/%0d want %0d/%0d", FlushCount, StallCycles, exp_flush, exp_stall); end
  endtask

  task automatic test_halt();
    for (int i = 1; i <= 16; i++) begin
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (ctl !== CTL_FREEZE || MemTimeout !== 1'b0) begin
        n_fail++; $display("FAIL halt_busy%0d: got %b/%b want %b/0", i, ctl, MemTimeout, CTL_FREEZE); end
      exp_stall += PERF;
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (ctl !== CTL_ZERO || MemTimeout !== 1'b1) begin
        n_fail++; $display("FAIL halt_hold%0d: got %b/%b want %b/1", i, ctl, MemTimeout, CTL_ZERO); end
    end
    n_cmp++; if (StallCycles !== 32'(exp_stall) || FlushCount !== 32'(exp_flush)) begin
      n_fail++; $display("FAIL halt_counts: got %0d/%0d want %0d/%0d", StallCycles, FlushCount, exp_stall, exp_flush); end
    #1 RST_n = 1'b0; #1;
    exp_stall = 0; exp_flush = 0;
    n_cmp++; if (ctl !== CTL_ZERO || MemTimeout !== 1'b0 || StallCycles !== 32'd0 || FlushCount !== 32'd0) begin
      n_fail++; $display("FAIL halt_reset: got %b/%b/%0d/%0d want %b/0/0/0", ctl, MemTimeout, StallCycles, FlushCount, CTL_ZERO); end
    @(negedge CLK); RST_n = 1'b1; EXMEM_BranchTaken = 1'b0; #2;
    n_cmp++; if (ctl !== CTL_RUN || MemTimeout !== 1'b0) begin
      n_fail++; $display("FAIL halt_release: got %b/%b want %b/0", ctl, MemTimeout, CTL_RUN); end
  endtask

  task automatic test_async_reset_wait();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      exp_stall += PERF;
    end
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1 RST_n = 1'b0; #1;
    exp_stall = 0; exp_flush = 0;
    n_cmp++; if (ctl !== CTL_ZERO || MemTimeout !== 1'b0 || StallCycles !== 32'd0 || FlushCount !== 32'd0) begin
      n_fail++; $display("FAIL async_rst_wait: got %b/%b/%0d/%0d want %b/0/0/0", ctl, MemTimeout, StallCycles, FlushCount, CTL_ZERO); end
    @(negedge CLK); RST_n = 1'b1; MemBusy = 1'b0; #2;
    n_cmp++; if (ctl !== CTL_RUN) begin n_fail++; $display("FAIL async_release: got %b want %b", ctl, CTL_RUN); end
    // Wait counter must restart from zero: 15 busy cycles stays short of HALT.
    for (int i = 0; i < 15; i++) begin
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      exp_stall += PERF;
    end
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ctl !== CTL_RUN || MemTimeout !== 1'b0) begin
      n_fail++; $display("FAIL wait15_no_halt: got %b/%b want %b/0", ctl, MemTimeout, CTL_RUN); end
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (MemTimeout !== 1'b0 || StallCycles !== 32'(exp_stall)) begin
      n_fail++; $display("FAIL wait15_counts: got %b/%0d want 0/%0d", MemTimeout, StallCycles, exp_stall); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mem_busy();
    test_halt();
    test_async_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
